// File: rtl/kbd_scan_fifo_pkg.sv
// Shared register map, bit positions, FSM state type and word-packing helpers
// for the keyboard scan-code FIFO slave.
package kbd_scan_pkg;

    localparam int ADDR_SEL_BIT     = 2;
    localparam bit REG_DATA         = 1'b0;
    localparam bit REG_STATUS_CTRL  = 1'b1;

    localparam int DATA_VALID_BIT   = 31;
    localparam int DATA_OVF_BIT     = 30;
    localparam int ST_OVF_BIT       = 31;
    localparam int ST_FULL_BIT      = 17;
    localparam int ST_EMPTY_BIT     = 16;
    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_OVF_BIT = 1;

    localparam logic [7:0] BREAK_CODE = 8'hF0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic [31:0] data_word(input logic valid, input logic ovf,
                                              input logic [7:0] data);
        logic [31:0] w;
        w = '0;
        w[DATA_VALID_BIT] = valid;
        w[DATA_OVF_BIT]   = ovf;
        w[7:0]            = valid ? data : 8'h00;
        return w;
    endfunction

    function automatic logic [31:0] status_word(input logic ovf, input logic full,
                                                input logic empty, input logic [7:0] cnt);
        logic [31:0] w;
        w = '0;
        w[ST_OVF_BIT]   = ovf;
        w[ST_FULL_BIT]  = full;
        w[ST_EMPTY_BIT] = empty;
        w[7:0]          = cnt;
        return w;
    endfunction

endpackage

// File: rtl/kbd_scan_fifo_if.sv
// Wishbone-style single-cycle-ACK bus bundle between interconnect and the keyboard slave.
interface kbd_scan_fifo_if;
    logic        STB;
    logic        WE;
    logic [31:0] ADDR;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK;

    modport slave  (input  STB, WE, ADDR, DAT_I, output DAT_O, ACK);
    modport master (output STB, WE, ADDR, DAT_I, input  DAT_O, ACK);
endinterface

// File: rtl/kbd_scan_fifo_sync_fifo.sv
// Single-clock FIFO with push/pop/flush, occupancy count and full/empty flags.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rd_q];

    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; pointers/count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/kbd_scan_fifo.sv
// Keyboard scan-code buffer slave: DATA (pop) / STATUS / CTRL registers, registered ACK.
// Optional KBD_BREAK_FILTER_EN drops 0xF0 and the byte following it.
module kbd_scan_fifo
    import kbd_scan_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           Keyboard_Data,
    input  logic                 ready_pulse,
    output logic [7:0]           LED,
    kbd_scan_fifo_if.slave       wb
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [31:0]   dat_q, dat_d;
    logic [7:0]    led_q;
    logic          ovf_q, ovf_d;
    logic          pop, flush, clr_ovf, push_req;
    logic [7:0]    rd_data;
    logic [CW-1:0] count;
    logic [7:0]    cnt8;
    logic          full, empty;
    logic          unused_bits;

    assign unused_bits = ^{wb.ADDR[31:3], wb.ADDR[1:0], wb.DAT_I[31:2]};
    assign cnt8        = 8'(count);

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_req & ~flush),
        .wdata_i (Keyboard_Data),
        .pop_i   (pop),
        .flush_i (flush),
        .rdata_o (rd_data),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef KBD_BREAK_FILTER_EN
    logic brk_q, brk_d;

    assign push_req = ready_pulse & ~brk_q & (Keyboard_Data != BREAK_CODE);

    always_comb begin
        brk_d = brk_q;
        if (flush)            brk_d = 1'b0;
        else if (ready_pulse) brk_d = ~brk_q & (Keyboard_Data == BREAK_CODE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) brk_q <= 1'b0;
        else        brk_q <= brk_d;
    end
`else
    assign push_req = ready_pulse;
`endif

    // Accesses are decoded in IDLE so pop and snapshot land on the edge ACK rises.
    always_comb begin
        state_d = state_q;
        dat_d   = dat_q;
        pop     = 1'b0;
        flush   = 1'b0;
        clr_ovf = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb.STB) begin
                    state_d = ST_RESP;
                    if (wb.WE) begin
                        if (wb.ADDR[ADDR_SEL_BIT] == REG_STATUS_CTRL) begin
                            flush   = wb.DAT_I[CTRL_FLUSH_BIT];
                            clr_ovf = wb.DAT_I[CTRL_CLR_OVF_BIT];
                        end
                    end else if (wb.ADDR[ADDR_SEL_BIT] == REG_DATA) begin
                        dat_d = data_word(~empty, ovf_q, rd_data);
                        pop   = ~empty;
                    end else begin
                        dat_d = status_word(ovf_q, full, empty, cnt8);
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A drop caused by a full FIFO is sticky and wins over a same-cycle clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)                    ovf_d = 1'b0;
        if (push_req & full & ~flush)   ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
            led_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dat_q   <= dat_d;
            ovf_q   <= ovf_d;
            if (ready_pulse) led_q <= Keyboard_Data;
        end
    end

    assign wb.DAT_O = dat_q;
    assign wb.ACK   = (state_q == ST_RESP);
    assign LED      = led_q;

endmodule

// File: tb/tb_kbd_scan_fifo.sv
// Directed bench for kbd_scan_fifo: register map, overflow, flush, push/pop overlap,
// optional break-code filter and reset during a response.
module tb_kbd_scan_fifo;

    logic        clk;
    logic        reset;
    logic [7:0]  Keyboard_Data;
    logic        ready_pulse;
    logic [7:0]  LED;
    logic [31:0] rd;
    int          checks;
    int          errors;

    kbd_scan_fifo_if bus ();

    kbd_scan_fifo #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .Keyboard_Data (Keyboard_Data),
        .ready_pulse   (ready_pulse),
        .LED           (LED),
        .wb            (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        Keyboard_Data = b;
        ready_pulse   = 1'b1;
        @(negedge clk);
        ready_pulse   = 1'b0;
    endtask

    // One bus transaction; optionally a keyboard push in the cycle STB is sampled.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic do_push,
                          input logic [7:0] pb, output logic [31:0] rdata);
        @(negedge clk);
        bus.STB   = 1'b1;
        bus.WE    = we;
        bus.ADDR  = addr;
        bus.DAT_I = wdata;
        if (do_push) begin
            Keyboard_Data = pb;
            ready_pulse   = 1'b1;
        end
        @(negedge clk);
        ready_pulse = 1'b0;
        chk({tag, "_ack_hi"}, {31'b0, bus.ACK}, 32'd1);
        rdata   = bus.DAT_O;
        bus.STB = 1'b0;
        bus.WE  = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_lo"}, {31'b0, bus.ACK}, 32'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        Keyboard_Data = 8'h00;
        ready_pulse   = 1'b0;
        bus.STB       = 1'b0;
        bus.WE        = 1'b0;
        bus.ADDR      = '0;
        bus.DAT_I     = '0;

        repeat (3) @(negedge clk);
        chk("rst_ack",  {31'b0, bus.ACK}, 32'd0);
        chk("rst_dato", bus.DAT_O, 32'h0);
        chk("rst_led",  {24'b0, LED}, 32'h0);
        reset = 1'b1;

        access("st0", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st0_val", rd, 32'h0001_0000);

        access("wdata", 1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0, 8'h00, rd);
        access("st1", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st1_val", rd, 32'h0001_0000);

        push(8'h1C);
        push(8'h32);
        chk("led_32", {24'b0, LED}, 32'h32);
        access("st2", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st2_val", rd, 32'h0000_0002);
        access("rd1", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("rd1_val", rd, 32'h8000_001C);
        access("rd2", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("rd2_val", rd, 32'h8000_0032);
        access("rd3", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("rd3_empty", rd, 32'h0000_0000);

        for (int i = 0; i < 17; i++) push(8'h40 + 8'(i));
        chk("led_drop", {24'b0, LED}, 32'h50);
        access("st_full", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st_full_val", rd, 32'h8002_0010);
        access("rd_ovf", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("rd_ovf_val", rd, 32'hC000_0040);
        access("ctrl3", 1'b1, 32'h4, 32'h3, 1'b0, 8'h00, rd);
        access("st_flush", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st_flush_val", rd, 32'h0001_0000);

        for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
        access("ovl", 1'b0, 32'h0, 32'h0, 1'b1, 8'hA6, rd);
        chk("ovl_val", rd, 32'h8000_00A1);
        access("st_ovl", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st_ovl_val", rd, 32'h0000_0005);
        for (int i = 2; i <= 6; i++) begin
            access("ord", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
            chk("ord_val", rd, 32'h8000_00A0 + 32'(i));
        end
        access("ord_end", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("ord_end_val", rd, 32'h0);

        push(8'h1C);
        push(8'hF0);
        push(8'h1C);
        push(8'h32);
        access("st_flt", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
`ifdef KBD_BREAK_FILTER_EN
        chk("st_flt_val", rd, 32'h0000_0002);
        access("flt1", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("flt1_val", rd, 32'h8000_001C);
        access("flt2", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("flt2_val", rd, 32'h8000_0032);
`else
        chk("st_flt_val", rd, 32'h0000_0004);
        access("flt1", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("flt1_val", rd, 32'h8000_001C);
        access("flt2", 1'b0, 32'h0, 32'h0, 1'b0, 8'h00, rd);
        chk("flt2_val", rd, 32'h8000_00F0);
`endif
        access("ctrl1", 1'b1, 32'h4, 32'h1, 1'b0, 8'h00, rd);

        push(8'h77);
        @(negedge clk);
        bus.STB  = 1'b1;
        bus.WE   = 1'b0;
        bus.ADDR = 32'h0;
        @(negedge clk);
        chk("mid_ack_hi", {31'b0, bus.ACK}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_ack_lo", {31'b0, bus.ACK}, 32'd0);
        chk("mid_led",    {24'b0, LED}, 32'h0);
        chk("mid_dato",   bus.DAT_O, 32'h0);
        bus.STB = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        access("st_post", 1'b0, 32'h4, 32'h0, 1'b0, 8'h00, rd);
        chk("st_post_val", rd, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
